// File: rtl/mole_game_core.sv
// mole_game_core
//   Timing and target-selection core for the whack-a-mole game.
//   A two-state controller (IDLE/RUN) runs a per-second prescaler and a
//   seconds countdown. Two 15-bit LFSRs (x^15+x^14+1) pick the good and bad
//   mole positions; both step once per game second. Two 4-to-16 decoders turn
//   the positions into one-hot cell enables.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no game; moles dark, countdown and LFSRs hold, waits for start
//   RUN   | game in progress; prescaler counts, countdown falls each second
//
// Ports
//   Clk            in   system clock, rising edge
//   Set            in   synchronous active-high reset (highest priority)
//   game_start     in   start request, accepted only in IDLE
//   seed[29:0]     in   [14:0] good LFSR seed, [29:15] bad LFSR seed
//   good_mole      out  one-hot good-mole position, 0 when idle
//   bad_mole       out  one-hot bad-mole position, 0 when idle
//   countdown      out  seconds remaining
//   gen_tick       out  high in the last cycle of each game second
//   decoder_enable out  high while running
//   reg_enable     out  high while running (score/hit register enable)
//   game_reset     out  one-cycle pulse in the first RUN cycle
module mole_game_core #(
    parameter int CYCLES_PER_SEC = 10,
    parameter int GAME_SECONDS   = 30
) (
    input  logic        Clk,
    input  logic        Set,
    input  logic        game_start,
    input  logic [29:0] seed,
    output logic [15:0] good_mole,
    output logic [15:0] bad_mole,
    output logic [4:0]  countdown,
    output logic        gen_tick,
    output logic        decoder_enable,
    output logic        reg_enable,
    output logic        game_reset
);

    localparam int PW = (CYCLES_PER_SEC > 2) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(CYCLES_PER_SEC - 1);
    localparam logic [4:0]    CD_LOAD = 5'(GAME_SECONDS);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t        state;
    logic [PW-1:0] prescaler;
    logic [14:0]   good_lfsr;
    logic [14:0]   bad_lfsr;
    logic          run;
    logic [3:0]    good_addr;
    logic [3:0]    bad_addr;

    function automatic logic [14:0] lfsr_step(input logic [14:0] v);
        return {v[13:0], v[14] ^ v[13]};
    endfunction

    // An all-zero LFSR would lock up, so a zero seed half becomes 1.
    function automatic logic [14:0] seed_fix(input logic [14:0] v);
        return (v == 15'h0000) ? 15'h0001 : v;
    endfunction

    assign run      = (state == S_RUN);
    assign gen_tick = run && (prescaler == PS_MAX);

    always_ff @(posedge Clk) begin
        if (Set) begin
            state      <= S_IDLE;
            prescaler  <= '0;
            countdown  <= '0;
            good_lfsr  <= 15'h0001;
            bad_lfsr   <= 15'h0001;
            game_reset <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    game_reset <= 1'b0;
                    if (game_start) begin
                        state      <= S_RUN;
                        prescaler  <= '0;
                        countdown  <= CD_LOAD;
                        good_lfsr  <= seed_fix(seed[14:0]);
                        bad_lfsr   <= seed_fix(seed[29:15]);
                        game_reset <= 1'b1;
                    end
                end
                S_RUN: begin
                    game_reset <= 1'b0;
                    if (gen_tick) begin
                        prescaler <= '0;
                        countdown <= countdown - 5'd1;
                        good_lfsr <= lfsr_step(good_lfsr);
                        bad_lfsr  <= lfsr_step(bad_lfsr);
                        // Last second elapsed: the game ends on this edge.
                        if (countdown == 5'd1) begin
                            state <= S_IDLE;
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    game_reset <= 1'b0;
                end
            endcase
        end
    end

    assign decoder_enable = run;
    assign reg_enable     = run;

    // The bad mole is bumped one cell over when it would land on the good one.
    assign good_addr = good_lfsr[3:0];
    assign bad_addr  = (bad_lfsr[3:0] == good_addr) ? good_addr + 4'd1 : bad_lfsr[3:0];

    always_comb begin
        good_mole = '0;
        bad_mole  = '0;
        if (decoder_enable) begin
            good_mole[good_addr] = 1'b1;
            bad_mole[bad_addr]   = 1'b1;
        end
    end

endmodule

// File: tb/tb_mole_game_core.sv
module tb_mole_game_core;

    localparam int CPS = 10;
    localparam int GS  = 30;

    logic        Clk;
    logic        Set;
    logic        game_start;
    logic [29:0] seed;
    logic [15:0] good_mole;
    logic [15:0] bad_mole;
    logic [4:0]  countdown;
    logic        gen_tick;
    logic        decoder_enable;
    logic        reg_enable;
    logic        game_reset;

    int n_tests = 0;
    int n_fail  = 0;

    mole_game_core #(.CYCLES_PER_SEC(CPS), .GAME_SECONDS(GS)) dut (
        .Clk            (Clk),
        .Set            (Set),
        .game_start     (game_start),
        .seed           (seed),
        .good_mole      (good_mole),
        .bad_mole       (bad_mole),
        .countdown      (countdown),
        .gen_tick       (gen_tick),
        .decoder_enable (decoder_enable),
        .reg_enable     (reg_enable),
        .game_reset     (game_reset)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural model: a game is described by the number of cycles elapsed
    // since the start edge; countdown and positions follow from that.
    bit          m_run = 1'b0;
    int          m_elapsed = 0;
    int          m_good = 1;
    int          m_bad = 1;
    int          m_cd = 0;
    bit          m_greset = 1'b0;
    bit          chk_en = 1'b0;

    function automatic int step15(input int v);
        int fb;
        fb = ((v >> 14) ^ (v >> 13)) & 1;
        return ((v << 1) & 32'h7FFF) | fb;
    endfunction

    function automatic int one_hot(input int a);
        return 1 << (a % 16);
    endfunction

    always @(posedge Clk) begin
        chk_en <= 1'b1;
        if (Set) begin
            m_run = 0; m_elapsed = 0; m_good = 1; m_bad = 1; m_cd = 0; m_greset = 0;
        end else if (!m_run) begin
            m_greset = 0;
            if (game_start) begin
                m_run     = 1;
                m_elapsed = 0;
                m_good    = (seed[14:0] == 0) ? 1 : int'(seed[14:0]);
                m_bad     = (seed[29:15] == 0) ? 1 : int'(seed[29:15]);
                m_cd      = GS;
                m_greset  = 1;
            end
        end else begin
            m_greset = 0;
            if (m_elapsed % CPS == CPS - 1) begin
                m_good = step15(m_good);
                m_bad  = step15(m_bad);
            end
            m_elapsed++;
            m_cd = GS - m_elapsed / CPS;
            if (m_elapsed == GS * CPS) m_run = 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        int ga, ba, eg, eb;
        if (chk_en) begin
            ga = m_good % 16;
            ba = m_bad % 16;
            if (ba == ga) ba = (ga + 1) % 16;
            eg = m_run ? one_hot(ga) : 0;
            eb = m_run ? one_hot(ba) : 0;
            chk("model_good_mole", int'(good_mole), eg);
            chk("model_bad_mole", int'(bad_mole), eb);
            chk("model_countdown", int'(countdown), m_cd);
            chk("model_gen_tick", int'(gen_tick), int'(m_run && (m_elapsed % CPS == CPS - 1)));
            chk("model_decoder_enable", int'(decoder_enable), int'(m_run));
            chk("model_reg_enable", int'(reg_enable), int'(m_run));
            chk("model_game_reset", int'(game_reset), int'(m_greset));
            chk("model_no_overlap", int'((good_mole & bad_mole) != 16'h0), 0);
        end
    end

    initial begin
        Set = 1'b1; game_start = 1'b0; seed = '0;
        repeat (5) @(negedge Clk);
        chk("reset_countdown", int'(countdown), 0);
        chk("reset_good", int'(good_mole), 0);
        chk("reset_bad", int'(bad_mole), 0);
        chk("reset_flags", int'({gen_tick, decoder_enable, reg_enable, game_reset}), 0);
        game_start = 1'b1;
        @(negedge Clk);
        chk("start_under_set", int'(decoder_enable), 0);
        game_start = 1'b0; Set = 1'b0;
        @(negedge Clk);

        // Game 1: known seed, full length, mid-game start ignored
        seed = 30'd123456789; game_start = 1'b1;
        @(negedge Clk);
        game_start = 1'b0;
        chk("start_countdown", int'(countdown), 30);
        chk("start_game_reset", int'(game_reset), 1);
        chk("start_good", int'(good_mole), 'h0020);
        chk("start_bad", int'(bad_mole), 'h0080);
        chk("start_enable", int'({decoder_enable, reg_enable}), 3);
        for (int k = 2; k <= 301; k++) begin
            @(negedge Clk);
            if (k == 2) chk("game_reset_pulse_end", int'(game_reset), 0);
            if (k == 10) chk("first_tick", int'(gen_tick), 1);
            if (k == 11) begin
                chk("tick_countdown", int'(countdown), 29);
                chk("tick_good", int'(good_mole), 'h0800);
                chk("tick_bad", int'(bad_mole), 'h4000);
                chk("tick_low", int'(gen_tick), 0);
            end
            if (k == 50) game_start = 1'b1;
            if (k == 51) begin
                game_start = 1'b0;
                chk("midgame_start_ignored", int'(countdown), 25);
            end
            if (k == 300) chk("last_cycle_running", int'({countdown, decoder_enable}), (1 << 1) | 1);
            if (k == 301) begin
                chk("end_countdown", int'(countdown), 0);
                chk("end_moles", int'(good_mole | bad_mole), 0);
                chk("end_enables", int'({decoder_enable, reg_enable}), 0);
            end
        end

        // Game 2: random seed, abort at countdown 17
        seed = 30'($urandom); game_start = 1'b1;
        @(negedge Clk);
        game_start = 1'b0;
        chk("restart_countdown", int'(countdown), 30);
        for (int k = 2; k <= 131; k++) @(negedge Clk);
        chk("abort_at_17", int'(countdown), 17);
        Set = 1'b1;
        @(negedge Clk);
        chk("abort_idle", int'({decoder_enable, reg_enable}), 0);
        chk("abort_moles", int'(good_mole | bad_mole), 0);
        Set = 1'b0; game_start = 1'b1;
        @(negedge Clk);
        game_start = 1'b0;
        chk("abort_restart", int'(countdown), 30);

        // Collision and zero seeds
        Set = 1'b1;
        @(negedge Clk);
        Set = 1'b0; seed = {15'h0005, 15'h0005}; game_start = 1'b1;
        @(negedge Clk);
        game_start = 1'b0;
        chk("collide_good", int'(good_mole), 'h0020);
        chk("collide_bad", int'(bad_mole), 'h0040);
        Set = 1'b1;
        @(negedge Clk);
        Set = 1'b0; seed = '0; game_start = 1'b1;
        @(negedge Clk);
        game_start = 1'b0;
        chk("zero_good", int'(good_mole), 'h0002);
        chk("zero_bad", int'(bad_mole), 'h0004);
        Set = 1'b1; game_start = 1'b1;
        @(negedge Clk);
        chk("set_beats_start", int'(decoder_enable), 0);
        Set = 1'b0; game_start = 1'b0;

        // Randomized play checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            @(negedge Clk);
            Set        = ($urandom_range(0, 299) == 0);
            game_start = ($urandom_range(0, 24) == 0);
            seed       = 30'($urandom);
            if ($urandom_range(0, 7) == 0) seed[14:0] = '0;
            if ($urandom_range(0, 7) == 0) seed[29:15] = '0;
        end
        Set = 1'b0; game_start = 1'b0;
        @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mole_game_core.md
# mole_game_core

Timing and target-selection core of the whack-a-mole game. It combines three parts:
- a game controller: start/run/end state machine, per-second prescaler and 5-bit countdown;
- two 15-bit LFSR position generators, one for the "good" mole and one for the "bad" mole;
- two 4-to-16 one-hot decoders that drive the mole cells.

It sits between the player start input and the per-cell mole/score logic. It supplies that logic with one-hot mole positions, a game-reset pulse and an enable for score registers.

## Interface
- CYCLES_PER_SEC, default 10: clock cycles per game second (prescaler modulus, ≥2).
- GAME_SECONDS, default 30: countdown load value (1..31).

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Set  in  1  synchronous active-high reset.
- game_start  in  1  start request, sampled each edge.
- seed  in  30  seed[14:0] is the good-generator seed; seed[29:15] is the bad-generator seed.
- good_mole  out  16  one-hot good-mole position, 0 when idle.
- bad_mole  out  16  one-hot bad-mole position, 0 when idle.
- countdown  out  5  seconds remaining.
- gen_tick  out  1  high in the last cycle of each game second.
- decoder_enable  out  1  high while running.
- reg_enable  out  1  high while running; enables downstream score/hit registers.
- game_reset  out  1  one-cycle pulse at game start; clears downstream score.

## Operation
- The controller has two states, IDLE and RUN.
- Set (synchronous, highest priority) forces:
  - state IDLE, countdown 0, prescaler 0;
  - both LFSRs to 15'h0001, game_reset 0;
  - all outputs 0.
- IDLE with game_start=1 at an edge moves to RUN. At that same edge:
  - countdown is loaded with GAME_SECONDS and the prescaler is cleared;
  - the good LFSR loads seed[14:0] and the bad LFSR loads seed[29:15];
  - an all-zero seed half is replaced by 15'h0001.
- game_start is ignored in RUN; a game cannot be restarted until it ends.
- RUN behaviour:
  - The prescaler counts 0..CYCLES_PER_SEC-1 and wraps.
  - gen_tick = (prescaler == CYCLES_PER_SEC-1).
  - At each edge with gen_tick=1, countdown decrements and both LFSRs step.
  - If countdown was 1 at that edge, it becomes 0 and the state returns to IDLE at the same edge.
- LFSR step (Fibonacci, x^15+x^14+1, maximal length): lfsr ← {lfsr[13:0], lfsr[14]^lfsr[13]}.
- Position addresses:
  - good_addr = good_lfsr[3:0].
  - bad_addr = bad_lfsr[3:0], except when it equals good_addr: then bad_addr = good_addr+1 mod 16 (15 wraps to 0).
  - Good and bad positions therefore never coincide.
- Decoders (combinational from registered state): good_mole = decoder_enable ? (1<<good_addr) : 0; bad_mole uses the same rule with bad_addr.
- decoder_enable = reg_enable = (state == RUN).
- game_reset is high only in the first RUN cycle, i.e. the cycle after start acceptance.

## Timing
- Latency from start: with game_start sampled at edge E0, moles, countdown=GAME_SECONDS and game_reset are all visible in the cycle after E0.
- First position change occurs at edge E0+CYCLES_PER_SEC; the k-th change occurs at E0+k·CYCLES_PER_SEC.
- Game end: RUN lasts exactly GAME_SECONDS·CYCLES_PER_SEC cycles. At the final edge, countdown reaches 0 and good_mole, bad_mole, decoder_enable and reg_enable drop together.
- Each position is held for a full second (CYCLES_PER_SEC cycles). GAME_SECONDS distinct display periods occur per game.
- After the game ends, countdown holds 0, and the LFSRs hold their values until the next start or Set.
- Set asserted mid-game aborts the game at that edge; a new start is accepted at the first edge after Set deasserts.
- Simultaneous Set and game_start: Set wins and the start is discarded.

## Test plan
- Reset: hold Set 5 cycles with defaults -> countdown=0, good_mole=bad_mole=0, all flags 0. Pulse game_start while Set=1 -> no start.
- Start: seed=123456789 (good 0x4D15, bad 0x0EB7), 1-cycle game_start -> next cycle countdown=30, game_reset=1 for 1 cycle, good_mole=0x0020, bad_mole=0x0080, decoder_enable=reg_enable=1.
- First tick: 10 cycles after the start edge -> gen_tick pulses 1 cycle, countdown=29, good LFSR 0x1A2B (good_mole=0x0800), bad LFSR 0x1D6E (bad_mole=0x4000).
- Full game: run 300 cycles -> countdown steps 30→0 once per 10 cycles, good_mole & bad_mole == 0 every RUN cycle, both outputs 0 and enables low exactly at cycle 300. game_start mid-game has no effect. A second start afterwards restarts from 30.
- Collision/zero seed: seed={15'h0005,15'h0005} -> good_mole=0x0020, bad_mole=0x0040. seed=0 -> both LFSRs 0x0001, good_mole=0x0002, bad_mole=0x0004.
- Abort: Set at countdown=17 -> next cycle IDLE, outputs 0. A new start reloads countdown to 30.
